shift_serdes: RTL



---
 rtl/shift_serdes_pkg.sv | 17 +
 rtl/shift_serdes_core.sv | 57 +++++
 rtl/shift_serdes.sv | 99 +++++++++
 3 files changed

// File: rtl/shift_serdes_pkg.sv
// Shared state encoding and sizing helper for the shift_serdes block.
`default_nettype none

package shift_serdes_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_serdes_core.sv
// +----------------------------------------------------------------------+
// | shift_serdes_core: shift register with load/shift/insert mux, o_s tap |
// | rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module shift_serdes_core #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_s,
  output logic             o_s,
  output logic [WIDTH-1:0] o_shifted
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] shifted;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shifted = {sr_q[WIDTH-2:0], i_s};
      assign o_s     = sr_q[WIDTH-1];
    end else begin : g_lsb_first
      assign shifted = {i_s, sr_q[WIDTH-1:1]};
      assign o_s     = sr_q[0];
    end
  endgenerate

  assign o_shifted = shifted;

  // A load wins over a shift so a back-to-back word replaces the finished one.
  always_comb begin
    sr_d = sr_q;
    if (i_load) begin
      sr_d = i_d;
    end else if (i_shift) begin
      sr_d = shifted;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/shift_serdes.sv
// +----------------------------------------------------------------------+
// | shift_serdes: full-duplex parallel<->serial shifter with valid/ready  |
// | Optional hold input enabled by defining SHIFT_SERDES_HOLD_EN. rev 1.0 |
// +----------------------------------------------------------------------+
`default_nettype none

module shift_serdes
  import shift_serdes_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_load,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_s,
`ifdef SHIFT_SERDES_HOLD_EN
  input  logic             i_hold,
`endif
  output logic             o_s,
  output logic             o_s_valid,
  output logic             o_last,
  output logic [WIDTH-1:0] o_q,
  output logic             o_done
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q;
  logic             done_q;
  logic             shift_en;
  logic             load_acc;
  logic [WIDTH-1:0] shifted;

`ifdef SHIFT_SERDES_HOLD_EN
  assign shift_en = ~i_hold;
`else
  assign shift_en = 1'b1;
`endif

  assign o_s_valid = (state_q == ST_SHIFT) && shift_en;
  assign o_last    = o_s_valid && (cnt_q == '0);
  assign o_ready   = (state_q == ST_IDLE) || o_last;
  assign load_acc  = i_load && o_ready;
  assign o_q       = q_q;
  assign o_done    = done_q;

  shift_serdes_core #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_core (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_load    (load_acc),
    .i_shift   (o_s_valid),
    .i_d       (i_d),
    .i_s       (i_s),
    .o_s       (o_s),
    .o_shifted (shifted)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (load_acc) begin
      state_d = ST_SHIFT;
      cnt_d   = CW'(WIDTH - 1);
    end else if (o_s_valid) begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= o_last;
      // Captured even when a new word loads on the same edge.
      if (o_last) begin
        q_q <= shifted;
      end
    end
  end

endmodule

`default_nettype wire
